// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants, state encoding and index helper for the round-robin
// 4:1 mux arbiter.
package rr_mux_arbiter_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;
   localparam int HOLD_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01
   } state_t;

   // Index 'step' positions after 'base', wrapping modulo NUM_REQ.
   function automatic logic [SEL_W-1:0] rotate_idx(input logic [SEL_W-1:0] base,
                                                   input int step);
      return base + SEL_W'(step);
   endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester data/request bundle and registered grant/data outputs of the
// round-robin mux arbiter.
interface rr_mux_arbiter_if #(
   parameter int DATA_W = 4
);
   import rr_mux_arbiter_pkg::*;

   logic [DATA_W-1:0]  a_in;
   logic [DATA_W-1:0]  b_in;
   logic [DATA_W-1:0]  c_in;
   logic [DATA_W-1:0]  d_in;
   logic [NUM_REQ-1:0] req_in;
   logic [NUM_REQ-1:0] grant;
   logic [SEL_W-1:0]   sel;
   logic [DATA_W-1:0]  out;
   logic               out_valid;

   modport master (
      output a_in, b_in, c_in, d_in, req_in,
      input  grant, sel, out, out_valid
   );

   modport slave (
      input  a_in, b_in, c_in, d_in, req_in,
      output grant, sel, out, out_valid
   );

endinterface

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational rotating priority encoder: first set request bit found when
// searching from ptr upward, wrapping around.
module rr_priority_pick
   import rr_mux_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic               found,
   output logic [SEL_W-1:0]   idx,
   output logic [NUM_REQ-1:0] onehot
);

   logic [SEL_W-1:0] cand_s;

   // Walk the requests in rotated order, keeping the first hit.
   always_comb begin
      found  = 1'b0;
      idx    = ptr;
      cand_s = ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand_s = rotate_idx(ptr, i);
         if (!found && req[cand_s]) begin
            found = 1'b1;
            idx   = cand_s;
         end else begin
            found = found;
            idx   = idx;
         end
      end
   end

   // Decode the winning index to a one-hot grant vector.
   always_comb begin
      if (found) begin
         onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
      end else begin
         onehot = {NUM_REQ{1'b0}};
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for a shared 4:1 data mux with capped grant tenure;
// grant, select and selected data are all registered.
module rr_mux_arbiter
   import rr_mux_arbiter_pkg::*;
#(
   parameter int DATA_W   = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   rr_mux_arbiter_if.slave  bus
);

   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

   state_t              state_r, state_n_s;
   logic [SEL_W-1:0]    ptr_r, ptr_n_s;
   logic [SEL_W-1:0]    sel_r, sel_n_s;
   logic [NUM_REQ-1:0]  grant_r, grant_n_s;
   logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_n_s;
   logic [DATA_W-1:0]   out_r, out_n_s, mux_s;
   logic                valid_r, valid_n_s;
   logic                keep_s;
   logic [SEL_W-1:0]    pick_ptr_s;
   logic                found_s;
   logic [SEL_W-1:0]    pick_idx_s;
   logic [NUM_REQ-1:0]  pick_onehot_s;

   // Holder keeps the path while it still requests and has tenure left;
   // on release the search starts just past the holder so handover is bubble-free.
   always_comb begin
      if (state_r == ST_BUSY) begin
         keep_s     = bus.req_in[sel_r] && (hold_cnt_r < HOLD_LIMIT);
         pick_ptr_s = sel_r + 2'd1;
      end else begin
         keep_s     = 1'b0;
         pick_ptr_s = ptr_r;
      end
   end

   rr_priority_pick u_pick (
      .req    (bus.req_in),
      .ptr    (pick_ptr_s),
      .found  (found_s),
      .idx    (pick_idx_s),
      .onehot (pick_onehot_s)
   );

   // Next-state, grant, pointer and tenure counter.
   always_comb begin
      state_n_s    = state_r;
      ptr_n_s      = ptr_r;
      sel_n_s      = sel_r;
      grant_n_s    = grant_r;
      hold_cnt_n_s = hold_cnt_r;
      valid_n_s    = valid_r;
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               state_n_s    = ST_BUSY;
               grant_n_s    = pick_onehot_s;
               sel_n_s      = pick_idx_s;
               hold_cnt_n_s = 8'd1;
               valid_n_s    = 1'b1;
            end else begin
               grant_n_s    = 4'b0000;
               hold_cnt_n_s = 8'd0;
               valid_n_s    = 1'b0;
            end
         end
         ST_BUSY: begin
            if (keep_s) begin
               hold_cnt_n_s = hold_cnt_r + 8'd1;
            end else begin
               ptr_n_s = sel_r + 2'd1;
               if (found_s) begin
                  grant_n_s    = pick_onehot_s;
                  sel_n_s      = pick_idx_s;
                  hold_cnt_n_s = 8'd1;
                  valid_n_s    = 1'b1;
               end else begin
                  state_n_s    = ST_IDLE;
                  grant_n_s    = 4'b0000;
                  hold_cnt_n_s = 8'd0;
                  valid_n_s    = 1'b0;
               end
            end
         end
         default: begin
            state_n_s    = ST_IDLE;
            grant_n_s    = 4'b0000;
            hold_cnt_n_s = 8'd0;
            valid_n_s    = 1'b0;
         end
      endcase
   end

   // Data mux steered by the next select; out freezes when nobody is granted.
   always_comb begin
      mux_s = sel_n_s[1] ? (sel_n_s[0] ? bus.d_in : bus.c_in)
                         : (sel_n_s[0] ? bus.b_in : bus.a_in);
      if (valid_n_s) begin
         out_n_s = mux_s;
      end else begin
         out_n_s = out_r;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         ptr_r      <= 2'd0;
         sel_r      <= 2'd0;
         grant_r    <= 4'b0000;
         hold_cnt_r <= 8'd0;
         out_r      <= {DATA_W{1'b0}};
         valid_r    <= 1'b0;
      end else begin
         state_r    <= state_n_s;
         ptr_r      <= ptr_n_s;
         sel_r      <= sel_n_s;
         grant_r    <= grant_n_s;
         hold_cnt_r <= hold_cnt_n_s;
         out_r      <= out_n_s;
         valid_r    <= valid_n_s;
      end
   end

   assign bus.grant     = grant_r;
   assign bus.sel       = sel_r;
   assign bus.out       = out_r;
   assign bus.out_valid = valid_r;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: directed vectors push expected results,
// an independent monitor pops and compares one cycle later.
module tb_rr_mux_arbiter;

   typedef struct {
      logic [3:0] grant;
      logic [1:0] sel;
      logic [3:0] out;
      logic       valid;
      string      tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   rr_mux_arbiter_if #(.DATA_W(4)) bus ();

   rr_mux_arbiter #(.DATA_W(4), .MAX_HOLD(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, expv, $time);
      end
   endtask

   task automatic drive(input logic [3:0] req, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d,
                        input logic [3:0] eg, input logic [1:0] es,
                        input logic [3:0] eo, input logic ev, input string tag);
      exp_t e;
      @(negedge clk);
      bus.req_in = req;
      bus.a_in   = a;
      bus.b_in   = b;
      bus.c_in   = c;
      bus.d_in   = d;
      e.grant = eg;
      e.sel   = es;
      e.out   = eo;
      e.valid = ev;
      e.tag   = tag;
      sb.push_back(e);
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_grant"}, 8'(bus.grant), 8'h00);
      chk({tag, "_sel"}, 8'(bus.sel), 8'h00);
      chk({tag, "_out"}, 8'(bus.out), 8'h00);
      chk({tag, "_valid"}, 8'(bus.out_valid), 8'h00);
   endtask

   // Monitor: compare registered outputs just after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, "_grant"}, 8'(bus.grant), 8'(e.grant));
            chk({e.tag, "_valid"}, 8'(bus.out_valid), 8'(e.valid));
            chk({e.tag, "_out"}, 8'(bus.out), 8'(e.out));
            chk({e.tag, "_onehot0"}, 8'($onehot0(bus.grant)), 8'h01);
            if (e.valid) begin
               chk({e.tag, "_sel"}, 8'(bus.sel), 8'(e.sel));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  owner;
      bit  own_c;
      logic [3:0] req;
      rst_n      = 1'b0;
      bus.req_in = 4'hF;
      bus.a_in   = 4'h0;
      bus.b_in   = 4'h0;
      bus.c_in   = 4'h0;
      bus.d_in   = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      chk_cleared("reset");
      rst_n = 1'b1;

      // All four request; each tenure lasts MAX_HOLD cycles, a..d then a again.
      for (int k = 0; k < 33; k++) begin
         owner = (k / 8) % 4;
         drive(4'hF, 4'(k + 3), 4'(k + 7), 4'(k + 11), 4'(k + 15),
               4'(1 << owner), 2'(owner), 4'(k + 3 + 4 * owner), 1'b1, "rot");
      end
      drive(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 4'h3, 1'b0, "rot_idle");

      // Lone b for three cycles, then idle with out frozen.
      repeat (3) drive(4'h2, 4'h1, 4'h5, 4'h9, 4'hD, 4'h2, 2'd1, 4'h5, 1'b1, "single");
      drive(4'h0, 4'h1, 4'h6, 4'h9, 4'hD, 4'h0, 2'd1, 4'h5, 1'b0, "single_idle");
      drive(4'h0, 4'h2, 4'h7, 4'hA, 4'hE, 4'h0, 2'd1, 4'h5, 1'b0, "single_idle2");

      // c granted, then asynchronous reset mid-tenure; ptr must restart at a.
      drive(4'h4, 4'h1, 4'h5, 4'h9, 4'hD, 4'h4, 2'd2, 4'h9, 1'b1, "mid_c");
      drive(4'h4, 4'h1, 4'h5, 4'hA, 4'hD, 4'h4, 2'd2, 4'hA, 1'b1, "mid_c");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_cleared("mid_rst");
      bus.req_in = 4'hF;
      rst_n = 1'b1;
      drive(4'hF, 4'h6, 4'h5, 4'hA, 4'hD, 4'h1, 2'd0, 4'h6, 1'b1, "post_rst");
      drive(4'h0, 4'h6, 4'h5, 4'hA, 4'hD, 4'h0, 2'd0, 4'h6, 1'b0, "post_rst_idle");

      // a holds, c joins at cycle 3; a capped after 8, c served, then a again.
      for (int j = 0; j < 12; j++) begin
         req   = ((j >= 3) && (j <= 10)) ? 4'h5 : 4'h1;
         own_c = (j >= 8) && (j <= 10);
         drive(req, 4'(j + 1), 4'h5, 4'(j + 8), 4'hD,
               own_c ? 4'h4 : 4'h1, own_c ? 2'd2 : 2'd0,
               own_c ? 4'(j + 8) : 4'(j + 1), 1'b1, "fair");
      end
      drive(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 4'hC, 1'b0, "fair_idle");

      // Lone d across two expiries: re-granted without dropping valid.
      for (int j = 0; j < 20; j++) begin
         drive(4'h8, 4'h1, 4'h5, 4'h9, 4'(j + 2), 4'h8, 2'd3, 4'(j + 2), 1'b1, "lone");
      end
      drive(4'h0, 4'h1, 4'h5, 4'h9, 4'h0, 4'h0, 2'd3, 4'h5, 1'b0, "lone_idle");

      repeat (3) @(posedge clk);
      #2;
      chk("sb_drain", 8'(sb.size()), 8'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
